// File: rtl/abofs_arbiter_pkg.sv
// Shared configuration constants for the abofs request arbiter; the TAU_* values mirror
// the pipeline-wide TauCfg settings (offset width, vector dims, config count).
package abofs_arbiter_pkg;
  localparam int   TAU_WORK_BW    = 8;
  localparam int   TAU_VDIM       = 2;
  localparam int   TAU_N_ICFG     = 6;
  localparam int   ABOFS_DROP_BW  = 16;
  localparam logic LAST_GRANT_RST = 1'b1;
endpackage

// File: rtl/abofs_arbiter_round_robin2.sv
// Combinational two-way round-robin grant: a lone requester wins, contention goes to
// the port that did not win last.
module abofs_arbiter_round_robin2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/abofs_arbiter.sv
// Merges two (bofs, aofs, config-range) request streams into one registered rdy/ack
// stream for the chunk head, tagging the source port and dropping empty ranges.
module abofs_arbiter
  import abofs_arbiter_pkg::*;
#(
  parameter int  WBW     = TAU_WORK_BW,
  parameter int  VDIM    = TAU_VDIM,
  parameter int  N_ICFG  = TAU_N_ICFG,
  parameter int  DROP_BW = ABOFS_DROP_BW,
  localparam int ICFG_BW = $clog2(N_ICFG + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,

  input  logic                          src0_rdy,
  output logic                          src0_ack,
  input  logic [VDIM-1:0][WBW-1:0]      src0_bofs,
  input  logic [VDIM-1:0][WBW-1:0]      src0_aofs,
  input  logic [ICFG_BW-1:0]            src0_beg,
  input  logic [ICFG_BW-1:0]            src0_end,

  input  logic                          src1_rdy,
  output logic                          src1_ack,
  input  logic [VDIM-1:0][WBW-1:0]      src1_bofs,
  input  logic [VDIM-1:0][WBW-1:0]      src1_aofs,
  input  logic [ICFG_BW-1:0]            src1_beg,
  input  logic [ICFG_BW-1:0]            src1_end,

  output logic                          dst_rdy,
  input  logic                          dst_ack,
  output logic                          dst_which,
  output logic [VDIM-1:0][WBW-1:0]      dst_bofs,
  output logic [VDIM-1:0][WBW-1:0]      dst_aofs,
  output logic [ICFG_BW-1:0]            dst_beg,
  output logic [ICFG_BW-1:0]            dst_end,
  output logic [DROP_BW-1:0]            o_drop_cnt
);

  logic [1:0]                     req;
  logic [1:0][VDIM-1:0][WBW-1:0]  bofs_arr;
  logic [1:0][VDIM-1:0][WBW-1:0]  aofs_arr;
  logic [1:0][ICFG_BW-1:0]        beg_arr;
  logic [1:0][ICFG_BW-1:0]        end_arr;

  assign req         = {src1_rdy, src0_rdy};
  assign bofs_arr[0] = src0_bofs;
  assign bofs_arr[1] = src1_bofs;
  assign aofs_arr[0] = src0_aofs;
  assign aofs_arr[1] = src1_aofs;
  assign beg_arr[0]  = src0_beg;
  assign beg_arr[1]  = src1_beg;
  assign end_arr[0]  = src0_end;
  assign end_arr[1]  = src1_end;

  logic last_grant;
  logic grant_valid;
  logic grant_idx;

  abofs_arbiter_round_robin2 u_rr (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  logic load_en;
  logic take;
  logic sel_empty;

  assign load_en   = !dst_rdy || dst_ack;
  assign take      = load_en && grant_valid && i_rst_n;
  assign src0_ack  = take && (grant_idx == 1'b0);
  assign src1_ack  = take && (grant_idx == 1'b1);
  assign sel_empty = (beg_arr[grant_idx] == end_arr[grant_idx]);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dst_rdy    <= 1'b0;
      dst_which  <= 1'b0;
      dst_bofs   <= '0;
      dst_aofs   <= '0;
      dst_beg    <= '0;
      dst_end    <= '0;
      o_drop_cnt <= '0;
      last_grant <= LAST_GRANT_RST;
    end else if (load_en) begin
      if (grant_valid) begin
        last_grant <= grant_idx;
        if (!sel_empty) begin
          dst_rdy   <= 1'b1;
          dst_which <= grant_idx;
          dst_bofs  <= bofs_arr[grant_idx];
          dst_aofs  <= aofs_arr[grant_idx];
          dst_beg   <= beg_arr[grant_idx];
          dst_end   <= end_arr[grant_idx];
        end else begin
          // load_en means either nothing is pending or it is leaving now
          dst_rdy <= 1'b0;
          if (o_drop_cnt != '1) begin
            o_drop_cnt <= o_drop_cnt + DROP_BW'(1);
          end
        end
      end else begin
        dst_rdy <= 1'b0;
      end
    end
  end

endmodule
